// File: rtl/config_pkg.sv
// Shared constants for the clock-divider configuration block: target
// addresses, index field position, lookup tables and reset defaults.
package config_pkg;

    // Write targets decoded from c_addr; 2'b00 and 2'b11 address nothing.
    localparam logic [1:0] ADDR_UART = 2'b01;
    localparam logic [1:0] ADDR_VGA  = 2'b10;

    // The table index lives in c_data[4:2]; all other data bits are ignored.
    localparam int IDX_MSB = 4;
    localparam int IDX_LSB = 2;
    localparam int IDX_W   = IDX_MSB - IDX_LSB + 1;

    // Resolution entry 7 is reserved and reads back as 640x480.
    localparam logic [IDX_W-1:0] IDX_RES_RESERVED = 3'd7;

    // Baud rates in bits/s, indexed 0..7.
    localparam logic [31:0] BAUD_TABLE [8] = '{
        32'd9600,
        32'd19200,
        32'd38400,
        32'd57600,
        32'd115200,
        32'd230400,
        32'd460800,
        32'd921600
    };

    // Resolutions as {h_pixels[31:16], v_lines[15:0]}, indexed 0..7.
    localparam logic [31:0] RES_TABLE [8] = '{
        32'h0280_01E0,  // 640x480
        32'h0320_0258,  // 800x600
        32'h0400_0300,  // 1024x768
        32'h0500_02D0,  // 1280x720
        32'h0500_0400,  // 1280x1024
        32'h0780_0438,  // 1920x1080
        32'h0640_0384,  // 1600x900
        32'h0280_01E0   // reserved, falls back to 640x480
    };

    // Values the divider registers hold coming out of reset.
    localparam logic [31:0] BAUD_RST = 32'd115200;
    localparam logic [31:0] RES_RST  = 32'h0280_01E0;

endpackage

// File: rtl/config_lut.sv
// Combinational index -> {baud, resolution, res_valid} lookup.
// res_valid is low only for the reserved resolution entry.
module config_lut
    import config_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [31:0]      baud,
    output logic [31:0]      res,
    output logic             res_valid
);

    // Pure table lookup; no state.
    always_comb begin
        baud      = BAUD_TABLE[idx];
        res       = RES_TABLE[idx];
        res_valid = (idx != IDX_RES_RESERVED);
    end

endmodule

// File: rtl/config_block.sv
// Runtime configuration registers for the UART and VGA clock dividers.
// Optional build macro: CONFIG_INDEX_CHECK_EN -- when defined, a VGA write
// selecting the reserved resolution index is rejected (no update, no ready).
//
// Handshake: a write is taken on any rising edge where c_valid=1 and c_addr
// names a target. There is no back-pressure; c_UART_ready / c_VGA_ready are
// registered acknowledgements that are high in the cycle after each edge on
// which a qualifying write was sampled, and low otherwise. At most one of
// them is high at a time.
module config_block
    import config_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        c_valid,
    input  logic [1:0]  c_addr,
    input  logic [7:0]  c_data,
    output logic        c_VGA_ready,
    output logic        c_UART_ready,
    output logic [31:0] baudrate,
    output logic [31:0] resolution
);

    logic [IDX_W-1:0] idx;
    logic [31:0]      lut_baud;
    logic [31:0]      lut_res;
    logic             lut_res_valid;

    logic             uart_wr;
    logic             vga_wr;

    logic [31:0]      baud_d, baud_q;
    logic [31:0]      res_d, res_q;
    logic             uart_rdy_d, uart_rdy_q;
    logic             vga_rdy_d, vga_rdy_q;

    // Data bits outside the index field carry no meaning.
    logic [4:0]       unused_data_bits;
    assign unused_data_bits = {c_data[7:5], c_data[1:0]};
    assign idx              = c_data[IDX_MSB:IDX_LSB];

    config_lut u_lut (
        .idx       (idx),
        .baud      (lut_baud),
        .res       (lut_res),
        .res_valid (lut_res_valid)
    );

`ifdef CONFIG_INDEX_CHECK_EN
    // Decode write targets; the reserved resolution index is refused.
    always_comb begin
        uart_wr = c_valid && (c_addr == ADDR_UART);
        vga_wr  = c_valid && (c_addr == ADDR_VGA) && lut_res_valid;
    end
`else
    // The reserved index is accepted and loads the fallback table entry.
    logic unused_res_valid;
    assign unused_res_valid = lut_res_valid;

    // Decode write targets.
    always_comb begin
        uart_wr = c_valid && (c_addr == ADDR_UART);
        vga_wr  = c_valid && (c_addr == ADDR_VGA);
    end
`endif

    // Next-state: load the looked-up value on a write, else hold.
    always_comb begin
        baud_d     = baud_q;
        res_d      = res_q;
        uart_rdy_d = uart_wr;
        vga_rdy_d  = vga_wr;
        if (uart_wr) begin
            baud_d = lut_baud;
        end
        if (vga_wr) begin
            res_d = lut_res;
        end
    end

    // State registers; reset wins over a write on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_q     <= BAUD_RST;
            res_q      <= RES_RST;
            uart_rdy_q <= 1'b0;
            vga_rdy_q  <= 1'b0;
        end else begin
            baud_q     <= baud_d;
            res_q      <= res_d;
            uart_rdy_q <= uart_rdy_d;
            vga_rdy_q  <= vga_rdy_d;
        end
    end

    assign baudrate     = baud_q;
    assign resolution   = res_q;
    assign c_UART_ready = uart_rdy_q;
    assign c_VGA_ready  = vga_rdy_q;

endmodule

// File: tb/tb_config_block.sv
// Self-checking bench for config_block: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_config_block;

    logic        clk;
    logic        rst;
    logic        c_valid;
    logic [1:0]  c_addr;
    logic [7:0]  c_data;
    logic        c_VGA_ready;
    logic        c_UART_ready;
    logic [31:0] baudrate;
    logic [31:0] resolution;

    int checks = 0;
    int errors = 0;

    // Expected outputs after the next edge: {baud, res, uart_rdy, vga_rdy}.
    logic [65:0] exp_q[$];

    // Reference tables written from the human-readable values.
    int unsigned ref_baud [8] = '{9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600};
    int unsigned ref_h    [8] = '{640, 800, 1024, 1280, 1280, 1920, 1600, 640};
    int unsigned ref_v    [8] = '{480, 600, 768, 720, 1024, 1080, 900, 480};

    // Model state.
    logic [31:0] m_baud;
    logic [31:0] m_res;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    config_block dut (
        .clk          (clk),
        .rst          (rst),
        .c_valid      (c_valid),
        .c_addr       (c_addr),
        .c_data       (c_data),
        .c_VGA_ready  (c_VGA_ready),
        .c_UART_ready (c_UART_ready),
        .baudrate     (baudrate),
        .resolution   (resolution)
    );

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: from the inputs about to be sampled, compute the outputs after the edge.
    task automatic model_step(input logic r, input logic v, input logic [1:0] a, input logic [7:0] d);
        int  i;
        logic urdy;
        logic vrdy;
        i    = int'(d[4:2]);
        urdy = 1'b0;
        vrdy = 1'b0;
        if (r) begin
            m_baud = 32'd115200;
            m_res  = {16'd640, 16'd480};
        end else if (v && a == 2'b01) begin
            m_baud = ref_baud[i];
            urdy   = 1'b1;
        end else if (v && a == 2'b10) begin
`ifdef CONFIG_INDEX_CHECK_EN
            if (i != 7) begin
                m_res = {ref_h[i][15:0], ref_v[i][15:0]};
                vrdy  = 1'b1;
            end
`else
            m_res = {ref_h[i][15:0], ref_v[i][15:0]};
            vrdy  = 1'b1;
`endif
        end
        exp_q.push_back({m_baud, m_res, urdy, vrdy});
    endtask

    // Scoreboard: compare every cycle that has an expectation queued.
    always @(posedge clk) begin
        logic [65:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("baudrate",     baudrate,             e[65:34]);
            check("resolution",   resolution,           e[33:2]);
            check("c_UART_ready", {31'd0, c_UART_ready}, {31'd0, e[1]});
            check("c_VGA_ready",  {31'd0, c_VGA_ready},  {31'd0, e[0]});
        end
    end

    // ---------------- driver ----------------
    task automatic drive_cycle(input logic r, input logic v, input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        rst     = r;
        c_valid = v;
        c_addr  = a;
        c_data  = d;
        model_step(r, v, a, d);
    endtask

    // Wait until just after the edge that samples the last driven inputs.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        m_baud  = 32'd0;
        m_res   = 32'd0;
        rst     = 1'b1;
        c_valid = 1'b0;
        c_addr  = 2'b00;
        c_data  = 8'h00;
        model_step(1'b1, 1'b0, 2'b00, 8'h00);
        settle();

        // Reset state.
        check("rst_baud", baudrate, 32'd115200);
        check("rst_res", resolution, 32'h028001E0);
        check("rst_rdy", {30'd0, c_UART_ready, c_VGA_ready}, 32'd0);

        // Invalid address held with valid for 38 cycles.
        for (int k = 0; k < 38; k++) drive_cycle(1'b0, 1'b1, 2'b00, 8'h00);
        settle();
        check("inv_baud", baudrate, 32'd115200);
        check("inv_rdy", {30'd0, c_UART_ready, c_VGA_ready}, 32'd0);

        // UART index 3, valid held.
        for (int k = 0; k < 4; k++) drive_cycle(1'b0, 1'b1, 2'b01, 8'h0C);
        settle();
        check("uart3_baud", baudrate, 32'd57600);
        check("uart3_rdy", {31'd0, c_UART_ready}, 32'd1);
        drive_cycle(1'b0, 1'b0, 2'b01, 8'h0C);
        settle();
        check("uart_rdy_drop", {31'd0, c_UART_ready}, 32'd0);

        // VGA index 5.
        for (int k = 0; k < 3; k++) drive_cycle(1'b0, 1'b1, 2'b10, 8'h14);
        settle();
        check("vga5_res", resolution, 32'h07800438);
        check("vga5_rdy", {31'd0, c_VGA_ready}, 32'd1);
        check("vga5_baud_kept", baudrate, 32'd57600);
        drive_cycle(1'b0, 1'b0, 2'b10, 8'h14);

        // VGA index 0 for two cycles.
        drive_cycle(1'b0, 1'b1, 2'b10, 8'h00);
        drive_cycle(1'b0, 1'b1, 2'b10, 8'h00);
        settle();
        check("vga0_res", resolution, 32'h028001E0);
        check("vga0_rdy", {31'd0, c_VGA_ready}, 32'd1);

        // Move to a non-default resolution, then try the reserved index.
        drive_cycle(1'b0, 1'b1, 2'b10, 8'h04);
        drive_cycle(1'b0, 1'b1, 2'b10, 8'h1C);
        settle();
`ifdef CONFIG_INDEX_CHECK_EN
        check("vga7_res", resolution, 32'h03200258);
        check("vga7_rdy", {31'd0, c_VGA_ready}, 32'd0);
`else
        check("vga7_res", resolution, 32'h028001E0);
        check("vga7_rdy", {31'd0, c_VGA_ready}, 32'd1);
`endif

        // Reset during a write: reset wins.
        drive_cycle(1'b0, 1'b1, 2'b01, 8'hFC);
        drive_cycle(1'b1, 1'b1, 2'b01, 8'h00);
        settle();
        check("rst_wr_baud", baudrate, 32'd115200);
        check("rst_wr_rdy", {31'd0, c_UART_ready}, 32'd0);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            drive_cycle(($urandom_range(0, 49) == 0),
                        ($urandom_range(0, 3) != 0),
                        2'($urandom_range(0, 3)),
                        8'($urandom_range(0, 255)));
        end
        drive_cycle(1'b0, 1'b0, 2'b00, 8'h00);
        settle();
        check("drain_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
